// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: bundle between the EX/hazard side and the PC redirect unit.
//   master : EX/hazard side. Drives pc_src, jump, target_addr, stall and fetch_ready.
//            Observes pc_out, pc_plus4, the two flushes, misalign_err and the counters.
//   slave  : the redirect unit. Directions are the reverse of master.
interface pc_redirect_unit_if;
  logic        pc_src;
  logic        jump;
  logic [31:0] target_addr;
  logic        stall;
  logic        fetch_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        misalign_err;
  logic [31:0] taken_cnt;
  logic [31:0] jump_cnt;

  modport master (
    output pc_src, jump, target_addr, stall, fetch_ready,
    input  pc_out, pc_plus4, flush_if_id, flush_id_ex, misalign_err, taken_cnt, jump_cnt
  );

  modport slave (
    input  pc_src, jump, target_addr, stall, fetch_ready,
    output pc_out, pc_plus4, flush_if_id, flush_id_ex, misalign_err, taken_cnt, jump_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with branch/jump redirect and a one-entry pending target.
//
// Ports:
//   i_clk    : clock. All state changes on the rising edge.
//   i_rst_n  : asynchronous active-low reset.
//   io_rdr   : pc_redirect_unit_if.slave.
//              Inputs : pc_src, jump, target_addr, stall, fetch_ready.
//              Outputs: pc_out (registered), pc_plus4 and the flushes (combinational),
//                       misalign_err (registered pulse), taken_cnt and jump_cnt.
// Parameter:
//   RESET_PC : fetch address loaded on reset.
// Configuration:
//   PC_REDIRECT_STATS_EN : when defined, the saturating taken/jump counters are built.
//                          When undefined, both counter outputs are tied to zero.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              i_clk,
  input logic              i_rst_n,
  pc_redirect_unit_if.slave io_rdr
);

  typedef enum logic {StIdle, StPending} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_pending_tgt;
  logic [31:0] w_pending_next;
  logic        r_misalign;
  logic        w_misalign_next;
  logic        w_redirect;
  logic [31:0] w_tgt_aligned;

  assign w_redirect    = io_rdr.pc_src | io_rdr.jump;
  assign w_tgt_aligned = {io_rdr.target_addr[31:2], 2'b00};

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state. A redirect that memory cannot accept yet parks in PENDING.
  // A later redirect with fetch_ready set goes straight back to IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_redirect && !io_rdr.fetch_ready) w_state_next = StPending;
      end
      StPending: begin
        if (io_rdr.fetch_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath next values. A redirect wins over both stall and any pending target.
  // Stall is honoured only for sequential fetch in IDLE.
  always_comb begin
    w_pc_next       = r_pc;
    w_pending_next  = r_pending_tgt;
    w_misalign_next = w_redirect && (io_rdr.target_addr[1:0] != 2'b00);
    if (w_redirect) begin
      w_pending_next = w_tgt_aligned;
      if (io_rdr.fetch_ready) w_pc_next = w_tgt_aligned;
    end else if (r_state == StPending) begin
      if (io_rdr.fetch_ready) w_pc_next = r_pending_tgt;
    end else if (!io_rdr.stall && io_rdr.fetch_ready) begin
      w_pc_next = r_pc + 32'd4;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_PC;
      r_pending_tgt <= 32'h0;
      r_misalign    <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_pending_tgt <= w_pending_next;
      r_misalign    <= w_misalign_next;
    end
  end

  assign io_rdr.pc_out       = r_pc;
  assign io_rdr.pc_plus4     = r_pc + 32'd4;
  assign io_rdr.flush_if_id  = w_redirect;
  assign io_rdr.flush_id_ex  = w_redirect;
  assign io_rdr.misalign_err = r_misalign;

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] r_taken_cnt;
  logic [31:0] r_jump_cnt;

  // Both counters step when pc_src and jump are set in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_taken_cnt <= 32'h0;
      r_jump_cnt  <= 32'h0;
    end else begin
      if (io_rdr.pc_src && (r_taken_cnt != 32'hFFFF_FFFF)) r_taken_cnt <= r_taken_cnt + 32'd1;
      if (io_rdr.jump && (r_jump_cnt != 32'hFFFF_FFFF))    r_jump_cnt  <= r_jump_cnt + 32'd1;
    end
  end

  assign io_rdr.taken_cnt = r_taken_cnt;
  assign io_rdr.jump_cnt  = r_jump_cnt;
`else
  assign io_rdr.taken_cnt = 32'h0;
  assign io_rdr.jump_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;
  pc_redirect_unit_if bus ();

  pc_redirect_unit #(.RESET_PC(RESET_PC)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_rdr (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: fetch PC, optional waiting target, error pulse, event counts.
  logic [31:0] m_pc;
  bit          m_pend_v;
  logic [31:0] m_pend;
  logic        m_mis;
  logic [31:0] m_taken;
  logic [31:0] m_jump;

  typedef struct {
    logic        ps;
    logic        j;
    logic [31:0] tgt;
    logic        st;
    logic        fr;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef PC_REDIRECT_STATS_EN
    return c;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_pend_v = 0;
    m_pend   = 32'h0;
    m_mis    = 1'b0;
    m_taken  = 32'h0;
    m_jump   = 32'h0;
  endtask

  // One clock of the reference model, using the inputs that were present at the edge.
  task automatic model_edge(input logic ps, input logic j, input logic [31:0] tgt,
                            input logic st, input logic fr);
    logic [31:0] at;
    at    = tgt & 32'hFFFF_FFFC;
    m_mis = (ps || j) && (tgt % 4 != 0);
    if (ps && m_taken != 32'hFFFF_FFFF) m_taken = m_taken + 1;
    if (j && m_jump != 32'hFFFF_FFFF)   m_jump  = m_jump + 1;
    if (ps || j) begin
      if (fr) begin
        m_pc     = at;
        m_pend_v = 0;
      end else begin
        m_pend   = at;
        m_pend_v = 1;
      end
    end else if (m_pend_v) begin
      if (fr) begin
        m_pc     = m_pend;
        m_pend_v = 0;
      end
    end else if (!st && fr) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Drive one cycle of inputs and check the combinational outputs before the edge.
  // Then check the registered outputs just after the edge.
  task automatic apply(input logic ps, input logic j, input logic [31:0] tgt,
                       input logic st, input logic fr);
    bus.pc_src      = ps;
    bus.jump        = j;
    bus.target_addr = tgt;
    bus.stall       = st;
    bus.fetch_ready = fr;
    #1;
    check("flush_if_id", {31'h0, bus.flush_if_id}, {31'h0, ps | j});
    check("flush_id_ex", {31'h0, bus.flush_id_ex}, {31'h0, ps | j});
    check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    @(posedge clk);
    model_edge(ps, j, tgt, st, fr);
    #1;
    check("pc_out", bus.pc_out, m_pc);
    check("misalign_err", {31'h0, bus.misalign_err}, {31'h0, m_mis});
    check("taken_cnt", bus.taken_cnt, exp_cnt(m_taken));
    check("jump_cnt", bus.jump_cnt, exp_cnt(m_jump));
  endtask

  // Assert reset part way through a cycle. Its effect must show without waiting for an edge.
  task automatic do_reset();
    bus.pc_src = 0; bus.jump = 0; bus.stall = 0; bus.fetch_ready = 0; bus.target_addr = 0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_pc_out", bus.pc_out, RESET_PC);
    check("rst_misalign", {31'h0, bus.misalign_err}, 32'h0);
    check("rst_taken_cnt", bus.taken_cnt, 32'h0);
    check("rst_jump_cnt", bus.jump_cnt, 32'h0);
    bus.pc_src = 1; bus.jump = 1;
    #1;
    check("rst_flush_if_id", {31'h0, bus.flush_if_id}, 32'h1);
    check("rst_flush_id_ex", {31'h0, bus.flush_id_ex}, 32'h1);
    bus.pc_src = 0; bus.jump = 0;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    //           ps  j   tgt            st  fr  exp_pc         mis
    vecs[0]  = '{0, 0, 32'h0,         0, 1, 32'h0000_0004, 0};
    vecs[1]  = '{0, 0, 32'h0,         0, 1, 32'h0000_0008, 0};
    vecs[2]  = '{0, 0, 32'h0,         0, 1, 32'h0000_000C, 0};
    vecs[3]  = '{0, 0, 32'h0,         0, 1, 32'h0000_0010, 0};
    vecs[4]  = '{0, 1, 32'h100,       0, 1, 32'h0000_0100, 0};
    vecs[5]  = '{1, 0, 32'h40,        1, 1, 32'h0000_0040, 0};  // redirect beats stall
    vecs[6]  = '{0, 1, 32'h200,       0, 0, 32'h0000_0040, 0};  // parked
    vecs[7]  = '{0, 0, 32'h0,         0, 0, 32'h0000_0040, 0};
    vecs[8]  = '{0, 0, 32'h0,         0, 0, 32'h0000_0040, 0};
    vecs[9]  = '{0, 0, 32'h0,         0, 1, 32'h0000_0200, 0};
    vecs[10] = '{0, 0, 32'h0,         0, 1, 32'h0000_0204, 0};
    vecs[11] = '{0, 1, 32'h200,       0, 0, 32'h0000_0204, 0};
    vecs[12] = '{1, 0, 32'h300,       0, 0, 32'h0000_0204, 0};  // replaces 0x200
    vecs[13] = '{0, 0, 32'h0,         0, 1, 32'h0000_0300, 0};
    vecs[14] = '{0, 0, 32'h0,         1, 1, 32'h0000_0300, 0};
    vecs[15] = '{0, 1, 32'h1003,      0, 1, 32'h0000_1000, 1};
    vecs[16] = '{0, 0, 32'h0,         0, 1, 32'h0000_1004, 0};
    vecs[17] = '{1, 0, 32'h2002,      1, 0, 32'h0000_1004, 1};
    vecs[18] = '{0, 0, 32'h0,         1, 1, 32'h0000_2000, 0};  // stall ignored in PENDING
    vecs[19] = '{1, 1, 32'h3000,      0, 1, 32'h0000_3000, 0};
    vecs[20] = '{0, 1, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFC, 1};
    vecs[21] = '{0, 0, 32'h0,         0, 1, 32'h0000_0000, 0};  // wraps to zero

    rst_n = 1'b0;
    bus.pc_src = 0; bus.jump = 0; bus.target_addr = 0; bus.stall = 0; bus.fetch_ready = 0;
    model_reset();
    #12;
    check("reset_pc_out", bus.pc_out, RESET_PC);
    check("reset_misalign", {31'h0, bus.misalign_err}, 32'h0);
    check("reset_taken_cnt", bus.taken_cnt, 32'h0);
    check("reset_jump_cnt", bus.jump_cnt, 32'h0);
    bus.pc_src = 1;
    #1;
    check("reset_flush_follows", {31'h0, bus.flush_if_id}, 32'h1);
    bus.pc_src = 0;
    #4;
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i].ps, vecs[i].j, vecs[i].tgt, vecs[i].st, vecs[i].fr);
      check($sformatf("vec%0d_pc", i), bus.pc_out, vecs[i].exp_pc);
      check($sformatf("vec%0d_mis", i), {31'h0, bus.misalign_err}, {31'h0, vecs[i].exp_mis});
    end

    // Event counters: 3 branch-only, 2 jump-only and 1 cycle with both set.
    do_reset();
    apply(1, 0, 32'h40, 0, 1);
    apply(1, 0, 32'h40, 0, 1);
    apply(1, 0, 32'h40, 0, 1);
    apply(0, 1, 32'h40, 0, 1);
    apply(0, 1, 32'h40, 0, 1);
    apply(1, 1, 32'h40, 0, 1);
`ifdef PC_REDIRECT_STATS_EN
    check("cnt_taken_total", bus.taken_cnt, 32'd4);
    check("cnt_jump_total", bus.jump_cnt, 32'd3);
`else
    check("cnt_taken_tied", bus.taken_cnt, 32'd0);
    check("cnt_jump_tied", bus.jump_cnt, 32'd0);
`endif
    do_reset();

    // A target parked in PENDING must be dropped by reset.
    apply(0, 1, 32'h500, 0, 0);
    do_reset();
    apply(0, 0, 32'h0, 0, 1);
    check("rst_drops_pending", bus.pc_out, RESET_PC + 32'd4);

    for (int n = 0; n < 400; n++) begin
      if (n % 97 == 96) begin
        do_reset();
      end else begin
        apply($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom,
              $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pc_src  input  1  conditional branch taken, resolved in EX by the branch unit.
REQ-005 jump  input  1  JAL/JALR in EX (unconditional redirect).
REQ-006 target_addr  input  32  redirect target computed in EX.
REQ-007 stall  input  1  hazard-unit request to hold IF.
REQ-008 fetch_ready  input  1  instruction memory accepts a new fetch address this cycle.
REQ-009 pc_out  output  32  current fetch PC (registered).
REQ-010 pc_plus4  output  32  pc_out + 4, combinational.
REQ-011 flush_if_id  output  1  squash IF/ID register; combinational.
REQ-012 flush_id_ex  output  1  squash ID/EX register; combinational.
REQ-013 misalign_err  output  1  one-cycle registered pulse: redirect target not word-aligned.
REQ-014 taken_cnt  output  32  count of taken conditional branches (see Configuration).
REQ-015 jump_cnt  output  32  count of jumps (see Configuration).

Function
REQ-016 redirect = pc_src | jump; flush_if_id = flush_id_ex = redirect, same cycle, no register.
REQ-017 States: IDLE, PENDING; held in pending_tgt (32 bit) plus state flag.
REQ-018 IDLE, redirect, fetch_ready=1: next edge pc_out <= {target_addr[31:2],2'b00}; stay IDLE; latency 1 cycle.
REQ-019 IDLE, redirect, fetch_ready=0: pending_tgt <= aligned target; go PENDING; pc_out held.
REQ-020 Redirect overrides stall: in IDLE, stall has no effect on a redirecting cycle.
REQ-021 IDLE, no redirect, stall=0, fetch_ready=1: pc_out <= pc_out + 4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 IDLE, no redirect, stall=1 or fetch_ready=0: pc_out held.
REQ-023 PENDING, fetch_ready=1, no redirect: pc_out <= pending_tgt; go IDLE; stall ignored.
REQ-024 PENDING, fetch_ready=0, no redirect: hold pc_out and pending_tgt.
REQ-025 PENDING, new redirect: pending_tgt overwritten with new aligned target; if fetch_ready=1, pc_out <= new target and go IDLE; else stay PENDING.
REQ-026 misalign_err asserted for exactly one cycle after any redirect cycle with target_addr[1:0] != 2'b00; PC still loads the aligned target.
REQ-027 pc_src and jump asserted together count as one redirect; both counters increment.

Reset
REQ-028 rst_n low asynchronously forces pc_out=RESET_PC, state IDLE, pending_tgt=0, misalign_err=0, taken_cnt=0, jump_cnt=0.
REQ-029 Reset asserted in PENDING discards pending_tgt; first edge after release behaves per IDLE rules.
REQ-030 flush outputs follow inputs during reset (combinational); consumers gate them with reset.

Configuration
REQ-031 Macro PC_REDIRECT_STATS_EN defined: taken_cnt increments on each cycle with pc_src=1, jump_cnt on each cycle with jump=1; both saturate at 32'hFFFF_FFFF.
REQ-032 Macro PC_REDIRECT_STATS_EN undefined: counter logic absent; taken_cnt and jump_cnt tied to 0; all other behaviour identical.

Verification
REQ-033 Reset release, stall=0, fetch_ready=1, 4 cycles -> pc_out 0x0,0x4,0x8,0xC; pc_plus4 tracks +4.
REQ-034 pc_out=0x100, pc_src=1, target=0x40, stall=1 same cycle -> flush_if_id=flush_id_ex=1 that cycle; next cycle pc_out=0x40.
REQ-035 jump=1, target=0x200, fetch_ready=0 for 3 cycles, then 1 -> pc_out held 3 cycles; next edge after fetch_ready=1, pc_out=0x200; then 0x204.
REQ-036 In PENDING (target 0x200), new pc_src=1 target=0x300 with fetch_ready=0, then fetch_ready=1 -> pc_out=0x300; 0x200 never fetched.
REQ-037 jump=1, target=0x1003 -> pc_out=0x1000 next cycle; misalign_err high exactly one cycle.
REQ-038 With PC_REDIRECT_STATS_EN: 3 pc_src pulses, 2 jump pulses, one cycle both -> taken_cnt=4, jump_cnt=3; rst_n pulse mid-run -> both 0, pc_out=RESET_PC immediately.
